load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage of the five-stage core: it accepts one ALU result per transaction from execute, performs the load or store against the synchronous data RAM, and hands a register-write packet to writeback. It implements RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW semantics over a word-wide RAM that has no byte mask. Sub-word stores therefore use an internal read-modify-write sequence. Non-memory instructions pass straight through with one cycle of latency.

## Interface
- READ_LATENCY, 1: cycles from address presented to valid ram_data_out (>=1).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  execute presents a transaction.
- in_ready  out  1  high only in IDLE; transfer occurs when in_valid && in_ready.
- in_mem_read  in  1  load.
- in_mem_write  in  1  store.
- in_reg_write  in  1  instruction writes rd (passed through for loads and non-memory ops).
- in_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- in_addr  in  32  ALU result: byte address, or the result value for non-memory ops.
- in_store_data  in  32  rs2 value.
- in_rd  in  5  destination register.
- ram_address  out  32  word index = addr[31:2] zero-extended.
- ram_data_in  out  32  write word.
- ram_write_enable  out  1  write strobe.
- ram_data_out  in  32  read word.
- out_valid  out  1  one-cycle pulse: result packet valid.
- out_data  out  32  load result or pass-through value.
- out_rd  out  5  destination register.
- out_reg_write  out  1  writeback enable; 0 for stores and faults.
- out_fault  out  1  misaligned or illegal access; no RAM write was performed.

## Operation
- Little-endian byte order: byte lane n occupies bits [8n+7:8n]. Lane select is addr[1:0].
- States:
  - IDLE: in_ready=1.
  - READ: address held, counter 0..READ_LATENCY.
  - WRITE: one cycle, write enable asserted.
  - DONE: out_valid=1, in_ready=0; next state is IDLE.
- All in_* fields are latched on acceptance. RAM outputs are driven from the latched copies only.
- Classification at acceptance, in priority order:
  1. Read and write both set: fault.
  2. funct3 in {011, 110, 111} with read or write set: fault.
  3. H/HU with addr[0]=1: fault.
  4. W with addr[1:0]!=0: fault.
  5. Neither read nor write: pass-through, out_data=in_addr.
  6. Load: READ state.
  7. SW: WRITE state.
  8. SB/SH: READ state, then WRITE state.
- Fault and pass-through transactions go IDLE -> DONE. A fault gives out_fault=1, out_reg_write=0, out_data=0.
- Load extraction:
  - B/BU: lane byte, sign- or zero-extended.
  - H/HU: half selected by addr[1], sign- or zero-extended.
  - W: full word.
- Store merge:
  - SB: the read word with lane addr[1:0] replaced by store_data[7:0].
  - SH: the read word with half addr[1] replaced by store_data[15:0].
  - SW: ram_data_in = store_data.
- ram_data_out is sampled when the READ counter reaches READ_LATENCY.
- ram_write_enable = (state==WRITE) && !rst. No write is ever issued in a reset cycle.
- ram_address holds its value throughout READ and WRITE. It is 0 in IDLE and DONE.

## Timing
- Acceptance in cycle T. out_valid is high in exactly one cycle:
  - Pass-through and fault: T+1.
  - SW: WRITE in T+1, out_valid in T+2.
  - Load: READ in T+1..T+1+L, out_valid in T+2+L (L=1 gives T+3).
  - SB/SH: READ in T+1..T+1+L, WRITE in T+2+L, out_valid in T+3+L.
- in_ready is low from T+1 until the cycle after out_valid. The earliest next acceptance is the cycle after DONE.
- in_valid while in_ready=0 is ignored. Execute must hold the transaction until it sees in_ready.
- out_data, out_rd, out_reg_write and out_fault are registered and hold their values until the next DONE.
- Reset values: state IDLE, in_ready=1 in the cycle after reset, all other outputs 0.
- Reset mid-transaction (READ or WRITE): abort with no write, no out_valid, and IDLE on the next cycle.
- rst together with in_valid: the transaction is not accepted.

## Test plan
- Reset during WRITE of SW addr 0x10 -> ram_write_enable=0 in that cycle; RAM word 4 unchanged; out_valid never asserted; in_ready=1 the next cycle.
- SW addr 0x10, data 0xDEADBEEF, then LW addr 0x10 (L=1):
  - Store: ram_address=4, we high exactly in T+1, out_valid T+2 with out_reg_write=0.
  - Load: out_valid T+3, out_data=0xDEADBEEF.
- With word 4 = 0x80FF7F01:
  - LB 0x13 -> 0xFFFFFF80.
  - LBU 0x13 -> 0x00000080.
  - LH 0x12 -> 0xFFFF80FF.
  - LHU 0x10 -> 0x00007F01.
- SB addr 0x11, data 0x000000AA over word 0x11223344 -> single write of 0x1122AA44 in T+3; out_valid T+4. Repeat with SH addr 0x12, data 0xBEEF -> 0xBEEFAA44.
- Faults, each with no write, out_fault=1 in T+1:
  - LW addr 0x12.
  - SH addr 0x11.
  - funct3=011 load.
  - read and write both set.
- Pass-through in_addr=0x1234, rd=7, reg_write=1 -> out_valid T+1, out_data=0x1234, out_rd=7. With L=3, LW latency = 5 cycles.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-access stage: runs loads and stores against a synchronous word-wide data RAM and
// emits one register-write packet per transaction. Sub-word stores use read-modify-write.
module load_store_unit #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_reg_write,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  output logic [31:0] ram_address,
  output logic [31:0] ram_data_in,
  output logic        ram_write_enable,
  input  logic [31:0] ram_data_out,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_fault
);

  localparam int unsigned CntW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(READ_LATENCY);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic            mem_read_q;
  logic            reg_write_q;
  logic [2:0]      funct3_q;
  logic [31:0]     addr_q;
  logic [15:0]     store_lo_q;
  logic [4:0]      rd_q;
  logic [31:0]     wdata_q;

  logic        access;
  logic        fault;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  // Alignment faults only apply to real memory accesses; ALU results are never checked.
  always_comb begin
    access = in_mem_read | in_mem_write;
    fault  = 1'b0;
    if (in_mem_read && in_mem_write) begin
      fault = 1'b1;
    end else if (access && (in_funct3 == 3'b011 || in_funct3[2:1] == 2'b11)) begin
      fault = 1'b1;
    end else if (access && in_funct3[1:0] == 2'b01 && in_addr[0]) begin
      fault = 1'b1;
    end else if (access && in_funct3 == 3'b010 && in_addr[1:0] != 2'b00) begin
      fault = 1'b1;
    end
  end

  always_comb begin
    lane_byte = ram_data_out[{addr_q[1:0], 3'b000} +: 8];
    lane_half = ram_data_out[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_val = {24'h000000, lane_byte};
      3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_val = {16'h0000, lane_half};
      default: load_val = ram_data_out;
    endcase
  end

  always_comb begin
    merge_val = ram_data_out;
    if (funct3_q[1:0] == 2'b00) begin
      merge_val[{addr_q[1:0], 3'b000} +: 8] = store_lo_q[7:0];
    end else begin
      merge_val[{addr_q[1], 4'b0000} +: 16] = store_lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      cnt           <= '0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_fault     <= 1'b0;
      mem_read_q    <= 1'b0;
      reg_write_q   <= 1'b0;
      funct3_q      <= '0;
      addr_q        <= '0;
      store_lo_q    <= '0;
      rd_q          <= '0;
      wdata_q       <= '0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            mem_read_q  <= in_mem_read;
            reg_write_q <= in_reg_write;
            funct3_q    <= in_funct3;
            addr_q      <= in_addr;
            store_lo_q  <= in_store_data[15:0];
            rd_q        <= in_rd;
            in_ready    <= 1'b0;
            cnt         <= '0;
            if (fault) begin
              state         <= StDone;
              out_valid     <= 1'b1;
              out_data      <= '0;
              out_rd        <= in_rd;
              out_reg_write <= 1'b0;
              out_fault     <= 1'b1;
            end else if (!access) begin
              state         <= StDone;
              out_valid     <= 1'b1;
              out_data      <= in_addr;
              out_rd        <= in_rd;
              out_reg_write <= in_reg_write;
              out_fault     <= 1'b0;
            end else if (in_mem_read || in_funct3 != 3'b010) begin
              state <= StRead;
            end else begin
              wdata_q <= in_store_data;
              state   <= StWrite;
            end
          end
        end
        StRead: begin
          if (cnt == CntLast) begin
            if (mem_read_q) begin
              state         <= StDone;
              out_valid     <= 1'b1;
              out_data      <= load_val;
              out_rd        <= rd_q;
              out_reg_write <= reg_write_q;
              out_fault     <= 1'b0;
            end else begin
              wdata_q <= merge_val;
              state   <= StWrite;
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        StWrite: begin
          state         <= StDone;
          out_valid     <= 1'b1;
          out_data      <= '0;
          out_rd        <= rd_q;
          out_reg_write <= 1'b0;
          out_fault     <= 1'b0;
        end
        StDone: begin
          state    <= StIdle;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ram_write_enable = (state == StWrite) && !rst;
  assign ram_address      = (state == StRead || state == StWrite) ? {2'b00, addr_q[31:2]} : '0;
  assign ram_data_in      = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model predicts packet timing, RAM
// writes and readiness, checked every cycle; a second instance covers a 3-cycle RAM.
module tb_load_store_unit;

  localparam int L = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ram_clear;
  logic        in_valid, in_ready, in_mem_read, in_mem_write, in_reg_write;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_store_data;
  logic [4:0]  in_rd;
  logic [31:0] ram_address, ram_data_in, ram_data_out;
  logic        ram_write_enable;
  logic        out_valid, out_reg_write, out_fault;
  logic [31:0] out_data;
  logic [4:0]  out_rd;

  logic        in_valid3, in_ready3, in_mem_read3, in_mem_write3;
  logic [31:0] in_addr3, in_store_data3;
  logic [31:0] ram_address3, ram_data_in3, ram_data_out3;
  logic        ram_write_enable3;
  logic        out_valid3, out_reg_write3, out_fault3;
  logic [31:0] out_data3;
  logic [4:0]  out_rd3;

  load_store_unit #(.READ_LATENCY(L)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_reg_write(in_reg_write),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_store_data(in_store_data), .in_rd(in_rd),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out),
    .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_fault(out_fault)
  );

  load_store_unit #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_mem_read(in_mem_read3), .in_mem_write(in_mem_write3), .in_reg_write(1'b1),
    .in_funct3(3'b010), .in_addr(in_addr3), .in_store_data(in_store_data3), .in_rd(5'd3),
    .ram_address(ram_address3), .ram_data_in(ram_data_in3),
    .ram_write_enable(ram_write_enable3), .ram_data_out(ram_data_out3),
    .out_valid(out_valid3), .out_data(out_data3), .out_rd(out_rd3),
    .out_reg_write(out_reg_write3), .out_fault(out_fault3)
  );

  // Bench RAMs: latency 1 for u_dut, latency 3 for u_dut3.
  logic [31:0] mem [0:63];
  logic [31:0] mem3 [0:63];
  logic [31:0] rd1, p0, p1, p2;
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 64; i++) begin
        mem[i]  <= '0;
        mem3[i] <= '0;
      end
    end else begin
      if (ram_write_enable) mem[ram_address[5:0]] <= ram_data_in;
      if (ram_write_enable3) mem3[ram_address3[5:0]] <= ram_data_in3;
    end
    rd1 <= mem[ram_address[5:0]];
    p0  <= mem3[ram_address3[5:0]];
    p1  <= p0;
    p2  <= p1;
  end
  assign ram_data_out  = rd1;
  assign ram_data_out3 = p2;

  int unsigned total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        fault;
    bit          chk_data;
    bit          chk_rd;
  } pkt_t;
  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  pkt_t        exp_q[$];
  wr_t         wr_q[$];
  logic [31:0] ref_mem [0:63];
  int          busy_lo = -1, busy_hi = -1;
  bit          chk_en = 0;

  always @(negedge clk) begin : cmp
    bit want_v, want_w, busy;
    if (chk_en) begin
      want_v = exp_q.size() > 0 && exp_q[0].cyc == cyc;
      check("out_valid", 32'(out_valid), 32'(want_v));
      if (want_v) begin
        if (exp_q[0].chk_data) check("out_data", out_data, exp_q[0].data);
        if (exp_q[0].chk_rd) check("out_rd", 32'(out_rd), 32'(exp_q[0].rd));
        check("out_reg_write", 32'(out_reg_write), 32'(exp_q[0].rw));
        check("out_fault", 32'(out_fault), 32'(exp_q[0].fault));
        void'(exp_q.pop_front());
      end
      want_w = wr_q.size() > 0 && wr_q[0].cyc == cyc;
      check("ram_write_enable", 32'(ram_write_enable), 32'(want_w));
      if (want_w) begin
        check("ram_address", ram_address, wr_q[0].addr);
        check("ram_data_in", ram_data_in, wr_q[0].data);
        void'(wr_q.pop_front());
      end
      busy = cyc >= busy_lo && cyc <= busy_hi;
      check("in_ready", 32'(in_ready), 32'(!busy));
      if (!busy) check("ram_address_idle", ram_address, 32'h0);
    end
  end

  // Present one transaction, predict its outcome, and wait until the unit is idle again.
  task automatic issue(input logic r, input logic w, input logic rw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                       input bit noise);
    int          t, voff;
    bit          mem_op, flt;
    logic [31:0] word, res, nw, mask, sh, lane, piece;
    pkt_t        p;
    wr_t         wr;
    t      = cyc;
    mem_op = r || w;
    flt    = (r && w) || (mem_op && (f3 == 3 || f3 == 6 || f3 == 7))
          || (mem_op && (f3 == 1 || f3 == 5) && a % 2 == 1)
          || (mem_op && f3 == 2 && a % 4 != 0);
    word   = ref_mem[(a / 4) % 64];
    lane   = a % 4;
    p.rd = rd; p.fault = 0; p.chk_data = 1; p.chk_rd = 1; p.data = 0; p.rw = 0;
    if (flt) begin
      voff = 1; p.fault = 1; p.chk_rd = 0;
    end else if (!mem_op) begin
      voff = 1; p.data = a; p.rw = rw;
    end else if (r) begin
      voff = 2 + L;
      p.rw = rw;
      if (f3 == 0 || f3 == 4) begin
        piece = (word >> (8 * lane)) & 32'hFF;
        res = piece;
        if (f3 == 0 && piece >= 128) res = piece + 32'hFFFFFF00;
      end else if (f3 == 1 || f3 == 5) begin
        piece = (word >> (16 * (lane / 2))) & 32'hFFFF;
        res = piece;
        if (f3 == 1 && piece >= 32768) res = piece + 32'hFFFF0000;
      end else begin
        res = word;
      end
      p.data = res;
    end else begin
      p.chk_data = 0;
      if (f3 == 2) begin
        nw = sd; wr.cyc = t + 1; voff = 2;
      end else begin
        sh   = (f3 == 0) ? 8 * lane : 16 * (lane / 2);
        mask = ((f3 == 0) ? 32'hFF : 32'hFFFF) << sh;
        nw   = (word & ~mask) | ((sd << sh) & mask);
        wr.cyc = t + 2 + L; voff = 3 + L;
      end
      wr.addr = a / 4; wr.data = nw;
      wr_q.push_back(wr);
      ref_mem[(a / 4) % 64] = nw;
    end
    p.cyc = t + voff;
    exp_q.push_back(p);
    busy_lo = t + 1; busy_hi = t + voff;
    in_mem_read = r; in_mem_write = w; in_reg_write = rw; in_funct3 = f3;
    in_addr = a; in_store_data = sd; in_rd = rd; in_valid = 1;
    @(posedge clk); #1;
    if (noise) begin
      in_mem_read = 0; in_mem_write = 0; in_addr = 32'h5555; in_rd = 5'd1;
    end else begin
      in_valid = 0;
    end
    repeat (voff) @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic run3(input logic r, input logic [31:0] a, input logic [31:0] sd,
                      output int lat, output logic [31:0] data);
    in_mem_read3 = r; in_mem_write3 = !r; in_addr3 = a; in_store_data3 = sd;
    in_valid3 = 1;
    @(posedge clk); #1 in_valid3 = 0;
    lat = 0; data = '0;
    for (int i = 1; i <= 20; i++) begin
      if (out_valid3) begin
        lat = i; data = out_data3;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat3;
    logic [31:0] d3;
    rst = 1; ram_clear = 1;
    in_valid = 0; in_mem_read = 0; in_mem_write = 0; in_reg_write = 0; in_funct3 = 0;
    in_addr = 0; in_store_data = 0; in_rd = 0;
    in_valid3 = 0; in_mem_read3 = 0; in_mem_write3 = 0; in_addr3 = 0; in_store_data3 = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    // A transaction offered while reset is held must not be taken.
    #1 in_valid = 1; in_addr = 32'h99; in_reg_write = 1; in_rd = 5'd9;
    @(posedge clk);
    #1 rst = 0; ram_clear = 0; in_valid = 0;
    check("reset in_ready", 32'(in_ready), 32'h1);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_data", out_data, 32'h0);
    check("reset out_rd", 32'(out_rd), 32'h0);
    check("reset out_reg_write", 32'(out_reg_write), 32'h0);
    check("reset out_fault", 32'(out_fault), 32'h0);
    check("reset ram_write_enable", 32'(ram_write_enable), 32'h0);
    check("reset ram_data_in", ram_data_in, 32'h0);
    chk_en = 1;
    @(posedge clk); #1;

    // Reset lands in the WRITE cycle of an SW: nothing written, no packet.
    begin
      int t;
      t = cyc;
      busy_lo = t + 1; busy_hi = t + 1;
      in_mem_read = 0; in_mem_write = 1; in_reg_write = 0; in_funct3 = 3'b010;
      in_addr = 32'h10; in_store_data = 32'h0BADF00D; in_rd = 0; in_valid = 1;
      @(posedge clk); #1 in_valid = 0; rst = 1;
      @(posedge clk); #1 rst = 0;
      repeat (2) @(posedge clk);
      #1 check("abort word4", mem[4], 32'h0);
    end

    issue(0, 1, 0, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 0);
    check("sw word4", mem[4], 32'hDEADBEEF);
    check("sw reg_write", 32'(out_reg_write), 32'h0);
    issue(1, 0, 1, 3'b010, 32'h10, 32'h0, 5'd5, 0);
    check("lw data", out_data, 32'hDEADBEEF);
    check("lw rd", 32'(out_rd), 32'd5);

    issue(0, 1, 0, 3'b010, 32'h10, 32'h80FF7F01, 5'd0, 0);
    issue(1, 0, 1, 3'b000, 32'h13, 32'h0, 5'd6, 0);
    check("lb 0x13", out_data, 32'hFFFFFF80);
    issue(1, 0, 1, 3'b100, 32'h13, 32'h0, 5'd6, 1);
    check("lbu 0x13", out_data, 32'h00000080);
    issue(1, 0, 1, 3'b001, 32'h12, 32'h0, 5'd6, 0);
    check("lh 0x12", out_data, 32'hFFFF80FF);
    issue(1, 0, 1, 3'b101, 32'h10, 32'h0, 5'd6, 0);
    check("lhu 0x10", out_data, 32'h00007F01);

    issue(0, 1, 0, 3'b010, 32'h10, 32'h11223344, 5'd0, 0);
    issue(0, 1, 0, 3'b000, 32'h11, 32'h000000AA, 5'd0, 0);
    check("sb merge", mem[4], 32'h1122AA44);
    issue(0, 1, 0, 3'b001, 32'h12, 32'h0000BEEF, 5'd0, 1);
    check("sh merge", mem[4], 32'hBEEFAA44);

    issue(1, 0, 1, 3'b010, 32'h12, 32'h0, 5'd8, 0);
    check("lw misaligned fault", 32'(out_fault), 32'h1);
    check("fault reg_write", 32'(out_reg_write), 32'h0);
    issue(0, 1, 0, 3'b001, 32'h11, 32'h1111, 5'd0, 0);
    check("sh misaligned fault", 32'(out_fault), 32'h1);
    issue(1, 0, 1, 3'b011, 32'h10, 32'h0, 5'd8, 1);
    check("funct3 011 fault", 32'(out_fault), 32'h1);
    check("fault data", out_data, 32'h0);
    issue(1, 1, 1, 3'b010, 32'h10, 32'h77777777, 5'd8, 0);
    check("rd+wr fault", 32'(out_fault), 32'h1);
    check("faults left word4", mem[4], 32'hBEEFAA44);

    issue(0, 0, 1, 3'b000, 32'h1234, 32'h0, 5'd7, 1);
    check("pass data", out_data, 32'h00001234);
    check("pass rd", 32'(out_rd), 32'd7);
    check("pass fault", 32'(out_fault), 32'h0);
    issue(1, 0, 1, 3'b010, 32'h10, 32'h0, 5'd4, 1);
    check("lw after merges", out_data, 32'hBEEFAA44);

    run3(0, 32'h20, 32'hCAFEF00D, lat3, d3);
    check("L3 sw latency", 32'(lat3), 32'd2);
    run3(1, 32'h20, 32'h0, lat3, d3);
    check("L3 lw latency", 32'(lat3), 32'd5);
    check("L3 lw data", d3, 32'hCAFEF00D);

    repeat (2) @(posedge clk);
    #1;
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      check("pending expectations", 32'(exp_q.size() + wr_q.size()), 32'h0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
